// File: rtl/rx_crc_ctrl_if.sv
// -----------------------------------------------------------------------------
// rx_crc_ctrl_if
//   Bundles the receive stream, the CRC checker handshake and the per-frame
//   status record of rx_crc_ctrl.
//   slave  : view of rx_crc_ctrl (consumes stream/checker/ready, drives the rest)
//   master : view of the surrounding logic (stream source, checker, stats sink)
// -----------------------------------------------------------------------------
interface rx_crc_ctrl_if #(
  parameter int LEN_W = 16
);
  // receive stream
  logic             frame_start;
  logic             frame_end;
  logic [7:0]       lane_valid;
  // checker verdict pulses
  logic             crc_check_valid;
  logic             crc_check_invalid;
  // checker controls
  logic             receiving_frame;
  logic [7:0]       crc_valid;
  logic             end_fcs;
  logic [2:0]       bits_more;
  // status record
  logic             stat_valid;
  logic             stat_ready;
  logic             stat_crc_ok;
  logic             stat_crc_err;
  logic             stat_timeout;
  logic [LEN_W-1:0] stat_len;
  logic             overrun;

  modport slave (
    input  frame_start, frame_end, lane_valid,
    input  crc_check_valid, crc_check_invalid,
    input  stat_ready,
    output receiving_frame, crc_valid, end_fcs, bits_more,
    output stat_valid, stat_crc_ok, stat_crc_err, stat_timeout, stat_len,
    output overrun
  );

  modport master (
    output frame_start, frame_end, lane_valid,
    output crc_check_valid, crc_check_invalid,
    output stat_ready,
    input  receiving_frame, crc_valid, end_fcs, bits_more,
    input  stat_valid, stat_crc_ok, stat_crc_err, stat_timeout, stat_len,
    input  overrun
  );
endinterface

// File: rtl/rx_crc_ctrl.sv
// -----------------------------------------------------------------------------
// rx_crc_ctrl
//   Sequencer for the receive-side 64-bit/8-bit CRC checker. Tracks frame
//   boundaries on the lane-aligned stream, drives the checker controls one
//   cycle behind the stream, waits (with timeout) for the checker verdict and
//   hands one status record per frame downstream over valid/ready.
// Ports
//   rxclk  : receive clock, all logic on posedge
//   reset  : asynchronous, active-high
//   bus    : rx_crc_ctrl_if.slave
//            in : frame_start, frame_end, lane_valid, crc_check_valid,
//                 crc_check_invalid, stat_ready
//            out: receiving_frame, crc_valid, end_fcs, bits_more, stat_valid,
//                 stat_crc_ok, stat_crc_err, stat_timeout, stat_len, overrun
// -----------------------------------------------------------------------------
module rx_crc_ctrl #(
  parameter int CHK_TIMEOUT = 16,
  parameter int LEN_W       = 16
) (
  input logic          rxclk,
  input logic          reset,
  rx_crc_ctrl_if.slave bus
);

  localparam int CNT_W = (CHK_TIMEOUT > 1) ? $clog2(CHK_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_WAIT_CHK,
    S_REPORT
  } state_e;

  state_e           state_q, state_d;
  logic             single_q, single_d;  // frame was one word; RECV only passes through
  logic             bad_q, bad_d;        // malformed lanes seen in this frame
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             rx_q, rx_d;
  logic [7:0]       crc_valid_q, crc_valid_d;
  logic             end_fcs_q, end_fcs_d;
  logic [2:0]       bits_more_q, bits_more_d;
  logic             stat_valid_q, stat_valid_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;
  logic             to_q, to_d;
  logic             overrun_q, overrun_d;

  logic [3:0]       lane_cnt;
  logic             lanes_ok;
  logic             lanes_zero;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // Contiguous-from-bit-0 means v+1 is a power of two: v & (v+1) == 0.
  function automatic logic lanes_contig(input logic [7:0] v);
    logic [8:0] p1;
    p1 = {1'b0, v} + 9'd1;
    return (({1'b0, v} & p1) == 9'd0);
  endfunction

  function automatic logic [LEN_W-1:0] sat_add(input logic [LEN_W-1:0] a,
                                               input logic [3:0]       b);
    logic [LEN_W:0] s;
    s = {1'b0, a} + {{(LEN_W-3){1'b0}}, b};
    return s[LEN_W] ? '1 : s[LEN_W-1:0];
  endfunction

  assign lane_cnt   = popcount8(bus.lane_valid);
  assign lanes_ok   = lanes_contig(bus.lane_valid);
  assign lanes_zero = (bus.lane_valid == 8'h00);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    single_d     = single_q;
    bad_d        = bad_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    rx_d         = 1'b0;
    crc_valid_d  = 8'h00;
    end_fcs_d    = 1'b0;
    bits_more_d  = bits_more_q;
    stat_valid_d = stat_valid_q;
    ok_d         = ok_q;
    err_d        = err_q;
    to_d         = to_q;
    overrun_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.frame_start) begin
          state_d     = S_RECV;
          single_d    = bus.frame_end;
          bad_d       = !lanes_ok || (bus.frame_end && lanes_zero);
          len_d       = LEN_W'(lane_cnt);
          rx_d        = 1'b1;
          crc_valid_d = bus.lane_valid;
          ok_d        = 1'b0;
          err_d       = 1'b0;
          to_d        = 1'b0;
          if (bus.frame_end) begin
            end_fcs_d   = 1'b1;
            bits_more_d = lane_cnt[2:0];
          end
        end
      end

      S_RECV: begin
        if (single_q) begin
          // Single-word frame already fully issued to the checker.
          state_d   = S_WAIT_CHK;
          single_d  = 1'b0;
          cnt_d     = '0;
          overrun_d = bus.frame_start;
        end else if (bus.frame_end) begin
          state_d     = S_WAIT_CHK;
          rx_d        = 1'b1;  // held through the final word's crc_valid
          crc_valid_d = bus.lane_valid;
          len_d       = sat_add(len_q, lane_cnt);
          bad_d       = bad_q || !lanes_ok || lanes_zero;
          end_fcs_d   = 1'b1;
          bits_more_d = lane_cnt[2:0];
          cnt_d       = '0;
        end else if (bus.frame_start) begin
          // Runt: drop what we had and restart on this word.
          rx_d        = 1'b1;
          crc_valid_d = bus.lane_valid;
          len_d       = LEN_W'(lane_cnt);
          bad_d       = !lanes_ok;
        end else begin
          rx_d        = 1'b1;
          crc_valid_d = bus.lane_valid;
          len_d       = sat_add(len_q, lane_cnt);
          bad_d       = bad_q || !lanes_ok;
        end
      end

      S_WAIT_CHK: begin
        overrun_d = bus.frame_start;
        if (bus.crc_check_invalid) begin
          state_d      = S_REPORT;
          stat_valid_d = 1'b1;
          err_d        = 1'b1;
        end else if (bus.crc_check_valid) begin
          state_d      = S_REPORT;
          stat_valid_d = 1'b1;
          ok_d         = !bad_q;
          err_d        = bad_q;
        end else if (cnt_q == CNT_W'(CHK_TIMEOUT - 1)) begin
          state_d      = S_REPORT;
          stat_valid_d = 1'b1;
          err_d        = 1'b1;
          to_d         = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_REPORT: begin
        overrun_d = bus.frame_start;
        if (bus.stat_ready) begin
          state_d      = S_IDLE;
          stat_valid_d = 1'b0;
          ok_d         = 1'b0;
          err_d        = 1'b0;
          to_d         = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      single_q     <= 1'b0;
      bad_q        <= 1'b0;
      cnt_q        <= '0;
      len_q        <= '0;
      rx_q         <= 1'b0;
      crc_valid_q  <= 8'h00;
      end_fcs_q    <= 1'b0;
      bits_more_q  <= 3'd0;
      stat_valid_q <= 1'b0;
      ok_q         <= 1'b0;
      err_q        <= 1'b0;
      to_q         <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      single_q     <= single_d;
      bad_q        <= bad_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      rx_q         <= rx_d;
      crc_valid_q  <= crc_valid_d;
      end_fcs_q    <= end_fcs_d;
      bits_more_q  <= bits_more_d;
      stat_valid_q <= stat_valid_d;
      ok_q         <= ok_d;
      err_q        <= err_d;
      to_q         <= to_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.receiving_frame = rx_q;
  assign bus.crc_valid       = crc_valid_q;
  assign bus.end_fcs         = end_fcs_q;
  assign bus.bits_more       = bits_more_q;
  assign bus.stat_valid      = stat_valid_q;
  assign bus.stat_crc_ok     = ok_q;
  assign bus.stat_crc_err    = err_q;
  assign bus.stat_timeout    = to_q;
  assign bus.stat_len        = len_q;
  assign bus.overrun         = overrun_q;

endmodule
